// File: rtl/rv32_pipe_pkg.sv
//==============================================================================
// Module      : rv32_pipe_pkg
// Description : Shared encodings for the RV32I pipeline hazard controller:
//               forwarding mux selects, result-source codes and the
//               memory-wait FSM state type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32_pipe_pkg;

  // E-stage operand forwarding selects
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  // ResultSrc code identifying a load
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // Memory-wait sequencer states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazState_t;

endpackage : rv32_pipe_pkg

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
//==============================================================================
// Module      : fwd_sel
// Description : Combinational forwarding select for one E-stage operand.
//               M-stage result wins over W-stage result; x0 never forwards.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_sel (
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] fwdSel
);
  import rv32_pipe_pkg::*;

  // Pick the youngest in-flight producer of rsE
  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule : fwd_sel

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module      : hazard_ctrl
// Description : Hazard and stall controller for the five-stage RV32I core.
//               Priority: data-memory wait > taken branch > load-use stall.
//               Optional macro HAZARD_PERF_CNT_EN adds stall/flush counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  input  logic       dmem_ready,
  output logic       dmem_valid,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  import rv32_pipe_pkg::*;

  // Last counter value before the access is aborted
  localparam logic [7:0] c_waitLast = 8'(MAX_WAIT - 1);

  hazState_t  r_state;
  logic [7:0] r_waitCnt;
  logic       r_memErr;

  logic       w_memStall;
  logic       w_timeout;
  logic       w_loadUse;
  logic [1:0] w_fwdA;
  logic [1:0] w_fwdB;

  // Timeout cycle itself is not stalled: the M instruction is let go
  assign w_timeout  = (r_state == MEM_WAIT) && !dmem_ready && (r_waitCnt == c_waitLast);

  assign w_memStall = ((r_state == MEM_WAIT) && !dmem_ready && (r_waitCnt != c_waitLast)) ||
                      ((r_state == RUN) && MemAccessM && !dmem_ready);

  assign w_loadUse  = (ResultSrcE == RESULT_SRC_MEM) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  fwd_sel u_fwdA (
    .rsE       (Rs1E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .fwdSel    (w_fwdA)
  );

  fwd_sel u_fwdB (
    .rsE       (Rs2E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .fwdSel    (w_fwdB)
  );

  // Memory-wait sequencer, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_waitCnt <= 8'd0;
      r_memErr  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (MemAccessM && !dmem_ready) begin
            r_state   <= MEM_WAIT;
            r_waitCnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= RUN;
          end else if (w_timeout) begin
            r_state  <= RUN;
            r_memErr <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign mem_err = r_memErr;

  // Zero-latency stall/flush/forward decode; reset forces bubbles into D and E
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b1;
    FlushE     = 1'b1;
    FlushW     = 1'b0;
    dmem_valid = 1'b0;
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    if (rst_n) begin
      ForwardAE = w_fwdA;
      ForwardBE = w_fwdB;
      if (w_memStall) begin
        StallF     = 1'b1;
        StallD     = 1'b1;
        StallE     = 1'b1;
        StallM     = 1'b1;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b1;
        dmem_valid = 1'b1;
      end else begin
        // A taken branch discards D, so a load-use stall on it is pointless
        StallF     = w_loadUse && !PCSrcE;
        StallD     = w_loadUse && !PCSrcE;
        FlushD     = PCSrcE;
        FlushE     = w_loadUse || PCSrcE;
        dmem_valid = MemAccessM;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushEvents;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= 32'd0;
      r_flushEvents <= 32'd0;
    end else begin
      if (StallF) r_stallCycles <= r_stallCycles + 32'd1;
      if (FlushE) r_flushEvents <= r_flushEvents + 32'd1;
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_events = r_flushEvents;
`endif

endmodule : hazard_ctrl

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//==============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking scoreboard bench for hazard_ctrl (MAX_WAIT=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int MAXW = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemAccessM, dmem_ready;
  logic       dmem_valid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  int unsigned expStall, expFlush;
`endif

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rwM, rwW;
    logic [1:0] resSrcE;
    logic       pc, memAcc, ready;
  } stim_t;

  typedef struct {
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushW, valid, err;
    logic [1:0] fwdA, fwdB;
  } exp_t;

  exp_t sbQ[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   mWait  = 0;   // consecutive stalled cycles of the current access
  logic mErr   = 1'b0;

  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemAccessM (MemAccessM),
    .dmem_ready (dmem_ready),
    .dmem_valid (dmem_valid),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .mem_err    (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [4:0] rs, input logic [4:0] rdM,
                                        input logic rwM, input logic [4:0] rdW, input logic rwW);
    if (rwM && rdM != 5'd0 && rdM == rs) return 2'b10;
    if (rwW && rdW != 5'd0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rs1D = 0; s.rs2D = 0; s.rs1E = 0; s.rs2E = 0;
    s.rdE = 0; s.rdM = 0; s.rdW = 0;
    s.rwM = 0; s.rwW = 0; s.resSrcE = 2'b00;
    s.pc = 0; s.memAcc = 0; s.ready = 1;
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    logic memStall, lu;
    memStall = ((mWait > 0) || s.memAcc) && !s.ready && (mWait < MAXW);
    lu = (s.resSrcE == 2'b01) && (s.rdE != 0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    e.fwdA = fwdRef(s.rs1E, s.rdM, s.rwM, s.rdW, s.rwW);
    e.fwdB = fwdRef(s.rs2E, s.rdM, s.rwM, s.rdW, s.rwW);
    e.err  = mErr;
    if (memStall) begin
      e.stallF = 1; e.stallD = 1; e.stallE = 1; e.stallM = 1;
      e.flushD = 0; e.flushE = 0; e.flushW = 1; e.valid = 1;
    end else begin
      e.stallF = lu && !s.pc; e.stallD = lu && !s.pc; e.stallE = 0; e.stallM = 0;
      e.flushD = s.pc; e.flushE = lu || s.pc; e.flushW = 0; e.valid = s.memAcc;
    end
    return e;
  endfunction

  // Apply one cycle of stimulus, score it at the negedge, advance the model
  task automatic runCycle(input string tag, input stim_t s);
    exp_t e;
    logic stalled;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW;
    RegWriteM = s.rwM; RegWriteW = s.rwW; ResultSrcE = s.resSrcE;
    PCSrcE = s.pc; MemAccessM = s.memAcc; dmem_ready = s.ready;
    sbQ.push_back(predict(s));
    @(negedge clk);
    e = sbQ.pop_front();
    checkVal({tag, ":StallF"}, 32'(StallF), 32'(e.stallF));
    checkVal({tag, ":StallD"}, 32'(StallD), 32'(e.stallD));
    checkVal({tag, ":StallE"}, 32'(StallE), 32'(e.stallE));
    checkVal({tag, ":StallM"}, 32'(StallM), 32'(e.stallM));
    checkVal({tag, ":FlushD"}, 32'(FlushD), 32'(e.flushD));
    checkVal({tag, ":FlushE"}, 32'(FlushE), 32'(e.flushE));
    checkVal({tag, ":FlushW"}, 32'(FlushW), 32'(e.flushW));
    checkVal({tag, ":dmem_valid"}, 32'(dmem_valid), 32'(e.valid));
    checkVal({tag, ":FwdA"}, 32'(ForwardAE), 32'(e.fwdA));
    checkVal({tag, ":FwdB"}, 32'(ForwardBE), 32'(e.fwdB));
    checkVal({tag, ":mem_err"}, 32'(mem_err), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
    if (e.stallF) expStall++;
    if (e.flushE) expFlush++;
`endif
    stalled = e.stallM;
    if (stalled) mWait++;
    else begin
      if (mWait == MAXW && !s.ready) mErr = 1'b1;
      mWait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOuts(input string tag);
    checkVal({tag, ":StallF"}, 32'(StallF), 0);
    checkVal({tag, ":StallM"}, 32'(StallM), 0);
    checkVal({tag, ":FlushD"}, 32'(FlushD), 1);
    checkVal({tag, ":FlushE"}, 32'(FlushE), 1);
    checkVal({tag, ":FlushW"}, 32'(FlushW), 0);
    checkVal({tag, ":dmem_valid"}, 32'(dmem_valid), 0);
    checkVal({tag, ":FwdA"}, 32'(ForwardAE), 0);
    checkVal({tag, ":mem_err"}, 32'(mem_err), 0);
  endtask

  task automatic resetModel();
    mWait = 0;
    mErr  = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    expStall = 0;
    expFlush = 0;
`endif
  endtask

  initial begin
    stim_t s;
    // Reset with hazardous inputs present: outputs must still be the reset values
    rst_n = 1'b0;
    Rs1D = 0; Rs2D = 7; Rs1E = 5; Rs2E = 0; RdE = 7; RdM = 5; RdW = 0;
    RegWriteM = 1; RegWriteW = 0; ResultSrcE = 2'b01;
    PCSrcE = 0; MemAccessM = 1; dmem_ready = 0;
    resetModel();
    #3;
    checkResetOuts("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Forwarding: M beats W, W when M is x0, none when both x0
    s = idle(); s.rdM = 5; s.rwM = 1; s.rdW = 5; s.rwW = 1; s.rs1E = 5; s.rs2E = 5;
    runCycle("fwdMprio", s);
    s.rdM = 0;                         runCycle("fwdWrdM0", s);
    s.rdM = 5; s.rwM = 0;              runCycle("fwdWnoRw", s);
    s.rdW = 0;                         runCycle("fwdX0", s);
    s = idle(); s.rdM = 3; s.rwM = 1; s.rdW = 9; s.rwW = 1; s.rs1E = 9; s.rs2E = 3;
    runCycle("fwdMixed", s);

    // Load-use hazard and its x0 exemption
    s = idle(); s.resSrcE = 2'b01; s.rdE = 7; s.rs2D = 7;
    runCycle("loadUse", s);
    runCycle("afterLU", idle());
    s.rdE = 0; s.rs2D = 0;             runCycle("loadUseX0", s);
    s = idle(); s.resSrcE = 2'b00; s.rdE = 7; s.rs1D = 7;
    runCycle("noLoad", s);

    // Branch overrides load-use
    s = idle(); s.resSrcE = 2'b01; s.rdE = 7; s.rs1D = 7; s.pc = 1;
    runCycle("brLU", s);
    s = idle(); s.pc = 1;              runCycle("branch", s);

    // Three wait cycles, release with a pending load-use
    s = idle(); s.memAcc = 1; s.ready = 0;
    for (int i = 0; i < 3; i++) runCycle("wait3", s);
    s.ready = 1; s.resSrcE = 2'b01; s.rdE = 4; s.rs1D = 4;
    runCycle("release", s);

    // Back-to-back access re-enters the wait
    s = idle(); s.memAcc = 1; s.ready = 1;  runCycle("b2bZero", s);
    s.ready = 0;                            runCycle("b2bWait", s);
    s.ready = 1;                            runCycle("b2bRel", s);
    runCycle("idle1", idle());

    // Timeout: ready never rises
    s = idle(); s.memAcc = 1; s.ready = 0;
    for (int i = 0; i < MAXW + 1; i++) runCycle("timeout", s);
    s = idle(); s.ready = 0;
    runCycle("errSticky1", s);
    runCycle("errSticky2", s);

`ifdef HAZARD_PERF_CNT_EN
    checkVal("stall_cycles", stall_cycles, expStall);
    checkVal("flush_events", flush_events, expFlush);
`endif

    // Reset pulse clears mem_err
    rst_n = 1'b0; #1;
    checkResetOuts("errReset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    runCycle("postErrReset", idle());

    // Reset asserted while waiting abandons the access
    s = idle(); s.memAcc = 1; s.ready = 0;
    runCycle("preRst", s);
    runCycle("preRst", s);
    rst_n = 1'b0; #1;
    checkResetOuts("rstInWait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    s = idle(); s.ready = 0;           runCycle("runAfterRst", s);
    s.memAcc = 1; s.ready = 1;         runCycle("zeroWaitAfterRst", s);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule : tb_hazard_ctrl

`default_nettype wire
